fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fetch_queue.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch queue sitting between the fetch stage and decode. Each cycle
// it can absorb one fetch bundle of up to FETCH_WIDTH instructions, compacting
// out lanes whose mask bit is clear. It presents up to DEQ_WIDTH of the oldest
// entries to decode, and decode reports how many it consumed.
//
// Parameters
//   FETCH_WIDTH  instructions per incoming bundle (1..4)
//   DEQ_WIDTH    instructions presented to decode per cycle (1..4)
//   DEPTH        entry count, power of two, >= FETCH_WIDTH + DEQ_WIDTH
//
// Ports
//   core_clock_i     sole clock, rising edge
//   core_reset_i     asynchronous active-low reset (clears pointers/count)
//   core_flush_i     synchronous flush: queue empties on the next edge
//   enq_valid_i      bundle offered
//   enq_mask_i       per-lane instruction valid
//   enq_instr_i      lane k at bits [32k+31:32k]
//   enq_pc_i         word PC of lane 0; lane k has PC enq_pc_i + k
//   enq_excp_vld_i   fetch fault for the bundle (stores a single entry)
//   enq_excp_code_i  fault code
//   enq_ptkn_i       per-lane predicted-taken flag
//   enq_busy_o       bundle cannot be accepted this cycle
//   deq_valid_o      thermometer, slot j valid when j < visible count
//   deq_instr_o, deq_pc_o, deq_excp_vld_o, deq_excp_code_o, deq_ptkn_o
//                    oldest entries, slot 0 oldest
//   deq_take_i       instructions consumed by decode this cycle
//   count_o          registered occupancy
//
// Configuration macro
//   FETCH_QUEUE_BYPASS_EN  when defined, a bundle accepted into an empty queue
//                          is visible on the deq outputs in the same cycle.
//                          When undefined, an accepted entry appears on the
//                          deq outputs one cycle after acceptance.
//
// Handshake: the enqueue side is valid/busy. A bundle is transferred on a
// rising edge exactly when enq_valid_i=1, enq_busy_o=0 and core_flush_i=0;
// enq_busy_o depends only on registered occupancy, never on same-cycle take or
// enqueue inputs. The dequeue side is a take count: decode may consume up to
// the number of valid slots; larger requests are clamped, never underflow.
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int FETCH_WIDTH = 2,
    parameter int DEQ_WIDTH   = 2,
    parameter int DEPTH       = 16
) (
    input  logic                             core_clock_i,
    input  logic                             core_reset_i,
    input  logic                             core_flush_i,
    input  logic                             enq_valid_i,
    input  logic [FETCH_WIDTH-1:0]           enq_mask_i,
    input  logic [32*FETCH_WIDTH-1:0]        enq_instr_i,
    input  logic [29:0]                      enq_pc_i,
    input  logic                             enq_excp_vld_i,
    input  logic [3:0]                       enq_excp_code_i,
    input  logic [FETCH_WIDTH-1:0]           enq_ptkn_i,
    output logic                             enq_busy_o,
    output logic [DEQ_WIDTH-1:0]             deq_valid_o,
    output logic [32*DEQ_WIDTH-1:0]          deq_instr_o,
    output logic [30*DEQ_WIDTH-1:0]          deq_pc_o,
    output logic [DEQ_WIDTH-1:0]             deq_excp_vld_o,
    output logic [4*DEQ_WIDTH-1:0]           deq_excp_code_o,
    output logic [DEQ_WIDTH-1:0]             deq_ptkn_o,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0]   deq_take_i,
    output logic [$clog2(DEPTH+1)-1:0]       count_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    // Compacted-bundle arrays are sized to serve both the write path
    // (FETCH_WIDTH lanes) and the bypass read path (DEQ_WIDTH slots).
    localparam int CMP = (FETCH_WIDTH > DEQ_WIDTH) ? FETCH_WIDTH : DEQ_WIDTH;

    // ------------------------------------------------------------------
    // Storage (no reset: contents are meaningless while count is zero)
    // ------------------------------------------------------------------
    logic [31:0] instr_mem     [DEPTH];
    logic [29:0] pc_mem        [DEPTH];
    logic        excp_vld_mem  [DEPTH];
    logic [3:0]  excp_code_mem [DEPTH];
    logic        ptkn_mem      [DEPTH];

    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [CW-1:0] count_q;

    // ------------------------------------------------------------------
    // Bundle compaction: valid lanes packed to the front in lane order
    // ------------------------------------------------------------------
    logic [31:0] comp_instr     [CMP];
    logic [29:0] comp_pc        [CMP];
    logic        comp_excp_vld  [CMP];
    logic [3:0]  comp_excp_code [CMP];
    logic        comp_ptkn      [CMP];
    int          enq_pos;
    logic [CW-1:0] enq_n;

    always_comb begin
        for (int i = 0; i < CMP; i++) begin
            comp_instr[i]     = '0;
            comp_pc[i]        = '0;
            comp_excp_vld[i]  = 1'b0;
            comp_excp_code[i] = '0;
            comp_ptkn[i]      = 1'b0;
        end
        enq_pos = 0;
        if (enq_excp_vld_i) begin
            // A faulting bundle collapses to one entry carrying lane 0 data,
            // whatever the mask says, so decode sees the fault exactly once.
            comp_instr[0]     = enq_instr_i[31:0];
            comp_pc[0]        = enq_pc_i;
            comp_excp_vld[0]  = 1'b1;
            comp_excp_code[0] = enq_excp_code_i;
            comp_ptkn[0]      = enq_ptkn_i[0];
            enq_pos           = 1;
        end else begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (enq_mask_i[k]) begin
                    comp_instr[enq_pos] = enq_instr_i[32*k +: 32];
                    comp_pc[enq_pos]    = enq_pc_i + 30'(k);
                    comp_ptkn[enq_pos]  = enq_ptkn_i[k];
                    enq_pos             = enq_pos + 1;
                end
            end
        end
        enq_n = CW'(enq_pos);
    end

    // ------------------------------------------------------------------
    // Acceptance, bypass, effective take
    // ------------------------------------------------------------------
    logic          accept;
    logic          bypass_act;
    logic [CW-1:0] enq_acc;
    logic [CW-1:0] vis_n;
    logic [CW-1:0] take_n;
    logic [CW-1:0] skip_n;

    assign enq_busy_o = (CW'(DEPTH) - count_q) < CW'(FETCH_WIDTH);

    // Gating with the reset keeps the deq outputs quiet during reset even
    // when the bypass path is compiled in.
    assign accept  = enq_valid_i & ~enq_busy_o & ~core_flush_i & core_reset_i;
    assign enq_acc = accept ? enq_n : '0;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_act = accept && (count_q == '0);
`else
    assign bypass_act = 1'b0;
`endif

    // Number of entries decode can see this cycle.
    assign vis_n = bypass_act ? enq_n : count_q;

    always_comb begin
        take_n = CW'(deq_take_i);
        if (take_n > vis_n) begin
            take_n = vis_n;
        end
        if (take_n > CW'(DEQ_WIDTH)) begin
            take_n = CW'(DEQ_WIDTH);
        end
    end

    // Bypassed lanes that decode consumes immediately are never written;
    // head and tail both skip over them so head stays equal to the first
    // entry still owed to decode.
    assign skip_n = bypass_act ? take_n : '0;

    // ------------------------------------------------------------------
    // Write port: lane i writes compacted entry (i + skip) at tail + i
    // ------------------------------------------------------------------
    logic          wr_en        [FETCH_WIDTH];
    logic [AW-1:0] wr_addr      [FETCH_WIDTH];
    logic [31:0]   wr_instr     [FETCH_WIDTH];
    logic [29:0]   wr_pc        [FETCH_WIDTH];
    logic          wr_excp_vld  [FETCH_WIDTH];
    logic [3:0]    wr_excp_code [FETCH_WIDTH];
    logic          wr_ptkn      [FETCH_WIDTH];

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            wr_en[i]        = 1'b0;
            wr_addr[i]      = tail_q + AW'(i);
            wr_instr[i]     = '0;
            wr_pc[i]        = '0;
            wr_excp_vld[i]  = 1'b0;
            wr_excp_code[i] = '0;
            wr_ptkn[i]      = 1'b0;
            for (int s = 0; s < CMP; s++) begin
                if (s == i + int'(skip_n)) begin
                    wr_en[i]        = accept && (CW'(s) < enq_n);
                    wr_instr[i]     = comp_instr[s];
                    wr_pc[i]        = comp_pc[s];
                    wr_excp_vld[i]  = comp_excp_vld[s];
                    wr_excp_code[i] = comp_excp_code[s];
                    wr_ptkn[i]      = comp_ptkn[s];
                end
            end
        end
    end

    always_ff @(posedge core_clock_i) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (wr_en[i]) begin
                instr_mem[wr_addr[i]]     <= wr_instr[i];
                pc_mem[wr_addr[i]]        <= wr_pc[i];
                excp_vld_mem[wr_addr[i]]  <= wr_excp_vld[i];
                excp_code_mem[wr_addr[i]] <= wr_excp_code[i];
                ptkn_mem[wr_addr[i]]      <= wr_ptkn[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge core_clock_i or negedge core_reset_i) begin
        if (!core_reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (core_flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + AW'(take_n - skip_n);
            tail_q  <= tail_q + AW'(enq_acc - skip_n);
            count_q <= count_q + enq_acc - take_n;
        end
    end

    assign count_o = count_q;

    // ------------------------------------------------------------------
    // Read port: slot j shows head + j, or the bundle itself when bypassing
    // ------------------------------------------------------------------
    logic [AW-1:0] rd_addr [DEQ_WIDTH];

    always_comb begin
        for (int j = 0; j < DEQ_WIDTH; j++) begin
            rd_addr[j]                = head_q + AW'(j);
            deq_valid_o[j]            = CW'(j) < vis_n;
            deq_instr_o[32*j +: 32]   = instr_mem[rd_addr[j]];
            deq_pc_o[30*j +: 30]      = pc_mem[rd_addr[j]];
            deq_excp_vld_o[j]         = excp_vld_mem[rd_addr[j]];
            deq_excp_code_o[4*j +: 4] = excp_code_mem[rd_addr[j]];
            deq_ptkn_o[j]             = ptkn_mem[rd_addr[j]];
            if (bypass_act) begin
                deq_instr_o[32*j +: 32]   = comp_instr[j];
                deq_pc_o[30*j +: 30]      = comp_pc[j];
                deq_excp_vld_o[j]         = comp_excp_vld[j];
                deq_excp_code_o[4*j +: 4] = comp_excp_code[j];
                deq_ptkn_o[j]             = comp_ptkn[j];
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue at default parameters (FETCH_WIDTH=2,
// DEQ_WIDTH=2, DEPTH=16). Stimulus is a linear sequence of steps: inputs are
// driven 1 ns after a rising edge, same-cycle (combinational) outputs are
// checked right after driving, then the bench advances one edge and checks the
// registered result. Expected instruction/PC streams live in queues filled
// from the bench's own stimulus values.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int FW    = 2;
    localparam int DW    = 2;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          enq_valid;
    logic [1:0]    enq_mask;
    logic [63:0]   enq_instr;
    logic [29:0]   enq_pc;
    logic          enq_excp_vld;
    logic [3:0]    enq_excp_code;
    logic [1:0]    enq_ptkn;
    logic          enq_busy;
    logic [1:0]    deq_valid;
    logic [63:0]   deq_instr;
    logic [59:0]   deq_pc;
    logic [1:0]    deq_excp_vld;
    logic [7:0]    deq_excp_code;
    logic [1:0]    deq_ptkn;
    logic [1:0]    deq_take;
    logic [4:0]    count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [29:0] exp_pc_q[$];

    fetch_queue #(
        .FETCH_WIDTH (FW),
        .DEQ_WIDTH   (DW),
        .DEPTH       (DEPTH)
    ) dut (
        .core_clock_i    (clk),
        .core_reset_i    (rst_n),
        .core_flush_i    (flush),
        .enq_valid_i     (enq_valid),
        .enq_mask_i      (enq_mask),
        .enq_instr_i     (enq_instr),
        .enq_pc_i        (enq_pc),
        .enq_excp_vld_i  (enq_excp_vld),
        .enq_excp_code_i (enq_excp_code),
        .enq_ptkn_i      (enq_ptkn),
        .enq_busy_o      (enq_busy),
        .deq_valid_o     (deq_valid),
        .deq_instr_o     (deq_instr),
        .deq_pc_o        (deq_pc),
        .deq_excp_vld_o  (deq_excp_vld),
        .deq_excp_code_o (deq_excp_code),
        .deq_ptkn_o      (deq_ptkn),
        .deq_take_i      (deq_take),
        .count_o         (count)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [63:0] ins,
                         input logic [29:0] pc, input logic ev, input logic [3:0] ec,
                         input logic [1:0] pt, input logic [1:0] take, input logic fl);
        enq_valid     = v;
        enq_mask      = m;
        enq_instr     = ins;
        enq_pc        = pc;
        enq_excp_vld  = ev;
        enq_excp_code = ec;
        enq_ptkn      = pt;
        deq_take      = take;
        flush         = fl;
        #1;
    endtask

    task automatic idle(input logic [1:0] take);
        drive(1'b0, 2'b00, 64'h0, 30'h0, 1'b0, 4'h0, 2'b00, take, 1'b0);
    endtask

    // Bundle whose lanes both carry an instruction word that encodes its PC.
    task automatic push_bundle(input logic [29:0] pc, input logic [1:0] take, input logic record);
        drive(1'b1, 2'b11, {2'b10, pc + 30'd1, 2'b10, pc}, pc, 1'b0, 4'h0, 2'b00, take, 1'b0);
        if (record) begin
            exp_q.push_back({2'b10, pc});
            exp_pc_q.push_back(pc);
            exp_q.push_back({2'b10, pc + 30'd1});
            exp_pc_q.push_back(pc + 30'd1);
        end
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Check both deq slots against the front of the scoreboard.
    task automatic chk_front2(input string tag);
        chk({tag, " valid"}, 64'(deq_valid), 64'h3);
        chk({tag, " instr0"}, 64'(deq_instr[31:0]), 64'(exp_q[0]));
        chk({tag, " instr1"}, 64'(deq_instr[63:32]), 64'(exp_q[1]));
        chk({tag, " pc1"}, 64'(deq_pc[59:30]), 64'(exp_pc_q[1]));
    endtask

    task automatic pop2();
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        void'(exp_pc_q.pop_front());
        void'(exp_pc_q.pop_front());
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        idle(2'd0);
        #20;
        chk("reset count", 64'(count), 64'd0);
        chk("reset deq_valid", 64'(deq_valid), 64'd0);
        chk("reset busy", 64'(enq_busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Mask 2'b10: only lane 1 stored, PC = base + 1.
        drive(1'b1, 2'b10, {32'hBBBB_0001, 32'hAAAA_0000}, 30'h100, 1'b0, 4'h0, 2'b10, 2'd0, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("mask bypass valid", 64'(deq_valid), 64'h1);
        chk("mask bypass instr", 64'(deq_instr[31:0]), 64'hBBBB_0001);
`else
        chk("mask same-cycle valid", 64'(deq_valid), 64'h0);
`endif
        tick();
        chk("mask count", 64'(count), 64'd1);
        chk("mask valid", 64'(deq_valid), 64'h1);
        chk("mask instr", 64'(deq_instr[31:0]), 64'hBBBB_0001);
        chk("mask pc", 64'(deq_pc[29:0]), 64'h101);
        chk("mask ptkn", 64'(deq_ptkn[0]), 64'h1);
        chk("mask excp", 64'(deq_excp_vld[0]), 64'h0);
        idle(2'd1);
        tick();
        chk("mask drained", 64'(count), 64'd0);

        // Fault bundle with full mask collapses to one entry.
        drive(1'b1, 2'b11, {32'hDDDD_0003, 32'hCCCC_0002}, 30'h200, 1'b1, 4'h1, 2'b00, 2'd0, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("excp bypass valid", 64'(deq_valid), 64'h1);
        chk("excp bypass vld", 64'(deq_excp_vld[0]), 64'h1);
        chk("excp bypass code", 64'(deq_excp_code[3:0]), 64'h1);
`else
        chk("excp same-cycle valid", 64'(deq_valid), 64'h0);
`endif
        tick();
        chk("excp count", 64'(count), 64'd1);
        chk("excp valid", 64'(deq_valid), 64'h1);
        chk("excp instr", 64'(deq_instr[31:0]), 64'hCCCC_0002);
        chk("excp pc", 64'(deq_pc[29:0]), 64'h200);
        chk("excp vld", 64'(deq_excp_vld[0]), 64'h1);
        chk("excp code", 64'(deq_excp_code[3:0]), 64'h1);
        idle(2'd1);
        tick();
        chk("excp drained", 64'(count), 64'd0);

        // Fill to DEPTH with 8 full bundles, no take.
        for (int b = 0; b < 8; b++) begin
            push_bundle(30'h300 + 30'(2 * b), 2'd0, 1'b1);
            tick();
            chk("fill count", 64'(count), 64'(2 * (b + 1)));
            chk("fill busy", 64'(enq_busy), (b == 7) ? 64'd1 : 64'd0);
        end
        // Ninth bundle dropped.
        push_bundle(30'h3F0, 2'd0, 1'b0);
        tick();
        chk("full drop count", 64'(count), 64'd16);
        // Busy holds despite same-cycle take; offered bundle also dropped.
        push_bundle(30'h3E0, 2'd2, 1'b0);
        chk("full busy with take", 64'(enq_busy), 64'd1);
        chk_front2("drain first");
        tick();
        pop2();
        chk("drain first count", 64'(count), 64'd14);
        for (int c = 0; c < 7; c++) begin
            idle(2'd2);
            chk_front2("drain");
            tick();
            pop2();
            chk("drain count", 64'(count), 64'(12 - 2 * c));
        end

        // Steady stream: 2 in, 2 out per cycle across pointer wrap.
        push_bundle(30'h1000, 2'd0, 1'b1);
        tick();
        chk("stream prefill count", 64'(count), 64'd2);
        for (int s = 1; s <= 20; s++) begin
            push_bundle(30'h1000 + 30'(2 * s), 2'd2, 1'b1);
            chk_front2("stream");
            tick();
            pop2();
            chk("stream count", 64'(count), 64'd2);
        end
        idle(2'd2);
        chk_front2("stream tail");
        tick();
        pop2();
        chk("stream empty", 64'(count), 64'd0);

        // Take larger than occupancy is clamped.
        drive(1'b1, 2'b01, {32'h0, 32'h5050_0000}, 30'h50, 1'b0, 4'h0, 2'b00, 2'd0, 1'b0);
        tick();
        idle(2'd3);
        chk("clamp valid", 64'(deq_valid), 64'h1);
        tick();
        chk("clamp count", 64'(count), 64'd0);
        chk("clamp busy", 64'(enq_busy), 64'd0);

        // Flush at count 5 with same-cycle enqueue and take.
        push_bundle(30'h600, 2'd0, 1'b0);
        tick();
        push_bundle(30'h602, 2'd0, 1'b0);
        tick();
        drive(1'b1, 2'b01, {32'h0, 32'h6060_0004}, 30'h604, 1'b0, 4'h0, 2'b00, 2'd0, 1'b0);
        tick();
        chk("pre-flush count", 64'(count), 64'd5);
        drive(1'b1, 2'b11, {32'hEEEE_0001, 32'hEEEE_0000}, 30'h700, 1'b0, 4'h0, 2'b00, 2'd2, 1'b1);
        tick();
        chk("flush count", 64'(count), 64'd0);
        chk("flush valid", 64'(deq_valid), 64'h0);
        drive(1'b1, 2'b11, {32'hF2F2_0002, 32'hF1F1_0001}, 30'h400, 1'b0, 4'h0, 2'b00, 2'd0, 1'b0);
        tick();
        chk("post-flush count", 64'(count), 64'd2);
        chk("post-flush instr0", 64'(deq_instr[31:0]), 64'hF1F1_0001);
        chk("post-flush instr1", 64'(deq_instr[63:32]), 64'hF2F2_0002);
        chk("post-flush pc1", 64'(deq_pc[59:30]), 64'h401);
        idle(2'd2);
        tick();
        chk("post-flush drained", 64'(count), 64'd0);

        // Reset asserted mid-fill at count 6.
        for (int b = 0; b < 3; b++) begin
            push_bundle(30'h800 + 30'(2 * b), 2'd0, 1'b0);
            tick();
        end
        idle(2'd0);
        chk("mid-fill count", 64'(count), 64'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset count", 64'(count), 64'd0);
        chk("async reset valid", 64'(deq_valid), 64'h0);
        chk("async reset busy", 64'(enq_busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("after reset count", 64'(count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
